// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_state_t   : access FSM states
//   F3_*          : RV32I funct3 size/sign encodings
//   f3_illegal    : funct3 not usable for the given direction
//   f3_misaligned : address not naturally aligned for the access size
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FLT
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: valid/ready data-memory port.
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : driven by the LSU (master)
//   mem_ready/mem_rdata                      : driven by the memory (slave)
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for one access.
//   funct3/addr_lo  : access size/sign and byte offset within the word
//   wdata_in        : raw store data (rs2)
//   rdata_in        : raw memory read word
//   be              : byte enables
//   wdata           : store data replicated across lanes
//   rdata_ext       : selected lane, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] lane;

  always_comb begin
    lane      = rdata_in >> {addr_lo, 3'b000};
    be        = 4'b1111;
    wdata     = wdata_in;
    rdata_ext = lane;
    // funct3[1:0] is the size, funct3[2] selects zero extension
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{wdata_in[7:0]}};
        rdata_ext = funct3[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{wdata_in[15:0]}};
        rdata_ext = funct3[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one load or store per start strobe over a valid/ready port.
//   clk, rst_n              : clock, async active-low reset
//   start, MemWrite, funct3 : request strobe (IDLE only), direction, size/sign
//   ALUResult, WriteData    : byte address, store data
//   busy, done, ReadData    : stall while in REQ, completion pulse, extended load data
//   misaligned, access_fault: fault flags, valid with done
//   mem                     : data-memory port (master side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        busy,
  output logic        done,
  output logic [31:0] ReadData,
  output logic        misaligned,
  output logic        access_fault,
  load_store_unit_if.master mem
);

  lsu_state_t  state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] cnt;
  logic        mis_q, flt_q;
  logic        req_ill, req_mis, timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata, rdata_ext;

  assign req_ill     = f3_illegal(MemWrite, funct3);
  assign req_mis     = f3_misaligned(funct3, ALUResult[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);

  lsu_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata_in  (wd_q),
    .rdata_in  (mem.mem_rdata),
    .be        (be),
    .wdata     (wdata),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (req_ill || req_mis) ? FLT : REQ;
      REQ: begin
        if (mem.mem_ready)    state_nx = RESP;
        else if (timeout_hit) state_nx = FLT;
      end
      RESP: state_nx = IDLE;
      FLT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory-side outputs come from latched command regs and are forced to
  // zero outside REQ so nothing leaks onto the bus between accesses.
  always_comb begin
    busy          = (state == REQ);
    done          = (state == RESP) || (state == FLT);
    misaligned    = (state == FLT) && mis_q;
    access_fault  = (state == FLT) && flt_q;
    mem.mem_req   = (state == REQ);
    mem.mem_we    = (state == REQ) && we_q;
    mem.mem_addr  = (state == REQ) ? {addr_q[31:2], 2'b00} : '0;
    mem.mem_be    = (state == REQ) ? be : '0;
    mem.mem_wdata = (state == REQ) ? wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      cnt      <= '0;
      mis_q    <= 1'b0;
      flt_q    <= 1'b0;
      ReadData <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            // illegal funct3 takes precedence over misalignment
            flt_q <= req_ill;
            mis_q <= !req_ill && req_mis;
            if (!(req_ill || req_mis)) begin
              we_q   <= MemWrite;
              f3_q   <= funct3;
              addr_q <= ALUResult;
              wd_q   <= WriteData;
            end
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            cnt <= '0;
            if (!we_q) ReadData <= rdata_ext;
          end else if (timeout_hit) begin
            cnt   <= '0;
            flt_q <= 1'b1;
            mis_q <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        busy, done, misaligned, access_fault;
  logic [31:0] ReadData;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  exp_t        sb[$];
  int unsigned req_cnt;

  load_store_unit_if mem ();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .MemWrite     (MemWrite),
    .funct3       (funct3),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .busy         (busy),
    .done         (done),
    .ReadData     (ReadData),
    .misaligned   (misaligned),
    .access_fault (access_fault),
    .mem          (mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, act as memory (ready after dly REQ cycles), and
  // compare the completion against the scoreboard entry pushed at issue.
  task automatic run_access(
    input string       name,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rdata,
    input int unsigned dly,
    input logic        exp_req,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rd,
    input logic        exp_mis,
    input logic        exp_flt,
    input int unsigned exp_lat,
    input bit          poke_start,
    output int unsigned req_cycles
  );
    exp_t e;
    bit   seen_req = 0;
    bit   got_done = 0;
    req_cycles = 0;
    e.rd = exp_rd; e.mis = exp_mis; e.flt = exp_flt;
    @(negedge clk);
    start = 1'b1; MemWrite = we; funct3 = f3; ALUResult = addr; WriteData = wd;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int unsigned c = 1; c <= 60 && !got_done; c++) begin
      if (c > 1) @(negedge clk);
      if (poke_start && c == 3) begin
        start = 1'b1; MemWrite = 1'b0; funct3 = F3_W; ALUResult = 32'h300;
      end else if (poke_start && c == 4) begin
        start = 1'b0;
      end
      if (mem.mem_req) begin
        if (!seen_req) begin
          check({name, "/addr"}, mem.mem_addr, {addr[31:2], 2'b00});
          check({name, "/we"}, {31'h0, mem.mem_we}, {31'h0, we});
          check({name, "/be"}, {28'h0, mem.mem_be}, {28'h0, exp_be});
          check({name, "/busy"}, {31'h0, busy}, 32'd1);
          if (we) check({name, "/wdata"}, mem.mem_wdata, exp_wdata);
        end
        seen_req = 1;
        req_cycles++;
        mem.mem_ready = (req_cycles > dly);
        mem.mem_rdata = rdata;
      end else begin
        mem.mem_ready = 1'b0;
      end
      if (done) begin
        got_done = 1;
        mem.mem_ready = 1'b0;
        if (sb.size() == 0) begin
          check({name, "/unexpected_done"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({name, "/rd"}, ReadData, e.rd);
          check({name, "/mis"}, {31'h0, misaligned}, {31'h0, e.mis});
          check({name, "/flt"}, {31'h0, access_fault}, {31'h0, e.flt});
        end
        check({name, "/busy_done"}, {31'h0, busy}, 32'd0);
        if (exp_lat != 0) check({name, "/lat"}, c, exp_lat);
      end
    end
    if (!got_done) check({name, "/done_timeout"}, 32'd0, 32'd1);
    check({name, "/req_seen"}, {31'h0, seen_req}, {31'h0, exp_req});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; MemWrite = 1'b0; funct3 = '0;
    ALUResult = '0; WriteData = '0;
    mem.mem_ready = 1'b0; mem.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst/busy", {31'h0, busy}, 32'd0);
    check("rst/done", {31'h0, done}, 32'd0);
    check("rst/rd", ReadData, 32'd0);
    check("rst/flags", {30'h0, misaligned, access_fault}, 32'd0);
    check("rst/req", {31'h0, mem.mem_req}, 32'd0);
    check("rst/bus", {mem.mem_we, mem.mem_be, 27'h0} | mem.mem_addr | mem.mem_wdata, 32'd0);
    rst_n = 1'b1;

    run_access("lw",   0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0, 1, 4'b1111, 0, 32'hDEADBEEF, 0, 0, 2, 0, req_cnt);
    run_access("lb",   0, F3_B,  32'h103, 0, 32'h80FF0000, 1, 1, 4'b1000, 0, 32'hFFFFFF80, 0, 0, 0, 0, req_cnt);
    run_access("lbu",  0, F3_BU, 32'h103, 0, 32'h80FF0000, 0, 1, 4'b1000, 0, 32'h00000080, 0, 0, 0, 0, req_cnt);
    run_access("lhu",  0, F3_HU, 32'h102, 0, 32'h80FF0000, 0, 1, 4'b1100, 0, 32'h000080FF, 0, 0, 0, 0, req_cnt);
    run_access("lh",   0, F3_H,  32'h102, 0, 32'h80FF0000, 2, 1, 4'b1100, 0, 32'hFFFF80FF, 0, 0, 0, 0, req_cnt);
    run_access("sb",   1, F3_B,  32'h102, 32'h12345678, 32'hFFFFFFFF, 0, 1, 4'b0100, 32'h78787878, 32'hFFFF80FF, 0, 0, 2, 0, req_cnt);
    run_access("sh",   1, F3_H,  32'h102, 32'h12345678, 32'hFFFFFFFF, 1, 1, 4'b1100, 32'h56785678, 32'hFFFF80FF, 0, 0, 0, 0, req_cnt);
    run_access("sw_wrap", 1, F3_W, 32'hFFFFFFFC, 32'hA5A50F0F, 0, 2, 1, 4'b1111, 32'hA5A50F0F, 32'hFFFF80FF, 0, 0, 0, 0, req_cnt);
    run_access("lb1",  0, F3_B,  32'h101, 0, 32'h00007F00, 0, 1, 4'b0010, 0, 32'h0000007F, 0, 0, 0, 0, req_cnt);
    run_access("lw_mis", 0, F3_W, 32'h101, 0, 0, 0, 0, 4'b0000, 0, 32'h0000007F, 1, 0, 0, 0, req_cnt);
    run_access("lh_mis", 0, F3_H, 32'h101, 0, 0, 0, 0, 4'b0000, 0, 32'h0000007F, 1, 0, 0, 0, req_cnt);
    run_access("ld_ill", 0, 3'b011, 32'h100, 0, 0, 0, 0, 4'b0000, 0, 32'h0000007F, 0, 1, 0, 0, req_cnt);
    run_access("ill_odd", 0, 3'b110, 32'h101, 0, 0, 0, 0, 4'b0000, 0, 32'h0000007F, 0, 1, 0, 0, req_cnt);
    run_access("st_ill", 1, F3_BU, 32'h100, 0, 0, 0, 0, 4'b0000, 0, 32'h0000007F, 0, 1, 0, 0, req_cnt);

    // memory never answers; a start strobe mid-REQ must not be queued
    run_access("tmo", 0, F3_W, 32'h200, 0, 32'h11111111, 1000, 1, 4'b1111, 0, 32'h0000007F, 0, 1, 17, 1, req_cnt);
    check("tmo/req_cycles", req_cnt, 32'd16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tmo/no_extra_done", {31'h0, done}, 32'd0);
      check("tmo/no_extra_req", {31'h0, mem.mem_req}, 32'd0);
    end

    // asynchronous reset in the middle of an access
    @(negedge clk);
    start = 1'b1; MemWrite = 1'b0; funct3 = F3_W; ALUResult = 32'h200;
    @(negedge clk);
    start = 1'b0;
    check("arst/req_before", {31'h0, mem.mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst/req", {31'h0, mem.mem_req}, 32'd0);
    check("arst/busy", {31'h0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst/no_done", {31'h0, done}, 32'd0);
    end
    rst_n = 1'b1;
    run_access("lw_post", 0, F3_W, 32'h200, 0, 32'h0BADF00D, 0, 1, 4'b1111, 0, 32'h0BADF00D, 0, 0, 2, 0, req_cnt);

    check("sb/empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
